// File: rtl/uart_receive.sv
// uart_receive: recovers 8N1/8N2 bytes from an asynchronous serial line
//   Clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   Serial       in   raw RX line, idle high
//   Data         out  [7:0] last correctly framed byte, held until the next good frame
//   Receive_Done out  one-cycle pulse, Data updated this cycle
//   Frame_Error  out  one-cycle pulse, stop bit sampled low
//   Busy         out  high from start-bit detection until return to IDLE
module uart_receive #(
  parameter int ClkFreq = 50000000,
  parameter int B_Rate  = 9600
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       Serial,
  output logic [7:0] Data,
  output logic       Receive_Done,
  output logic       Frame_Error,
  output logic       Busy
);
  localparam int CLKS_PER_BIT = ClkFreq / B_Rate;
  localparam logic [31:0] LAST = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF = 32'((CLKS_PER_BIT - 1) / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t      state_q, state_d;
  logic        rx_m_q, rx_s_q;
  logic [31:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        clk_count_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (clk_count_q == HALF) begin
          clk_count_d = '0;
          bit_idx_d   = '0;
          // a line that is high again at mid start bit was only a glitch
          state_d     = rx_s_q ? IDLE : DATA;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end
      DATA: begin
        if (clk_count_q == LAST) begin
          clk_count_d        = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end
      STOP: begin
        if (clk_count_q == LAST) begin
          clk_count_d = '0;
          data_d      = rx_s_q ? shift_q : data_q;
          done_d      = rx_s_q;
          ferr_d      = !rx_s_q;
          state_d     = rx_s_q ? IDLE : BRK;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end
      BRK: begin
        // a held-low line reports one error, then waits for release
        clk_count_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        clk_count_d = '0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_m_q      <= Serial;
      rx_s_q      <= rx_m_q;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end
  assign Data         = data_q;
  assign Receive_Done = done_q;
  assign Frame_Error  = ferr_q;
  assign Busy         = busy_q;
endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: randomized scoreboard bench for uart_receive at 16 clocks per bit
module tb_uart_receive;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial = 1'b1;
  logic [7:0] data;
  logic       done, ferr, busy;
  always #5 clk = ~clk;
  uart_receive #(.ClkFreq(16), .B_Rate(1)) dut (
    .Clk(clk), .reset_n(reset_n), .Serial(serial), .Data(data),
    .Receive_Done(done), .Frame_Error(ferr), .Busy(busy)
  );
  typedef struct {bit err; logic [7:0] d; int t0;} ev_t;
  ev_t        exp_q[$];
  ev_t        cur;
  int         checks = 0, errors = 0, cyc = 0, lat;
  logic [7:0] last_good = 8'h00;
  bit         prev_pulse = 1'b0;
  bit         seen;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done || ferr) begin
      chk("pulse_exclusive", {31'd0, done && ferr}, 0);
      chk("pulse_width", {31'd0, prev_pulse}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b ferr=%0b data=%02h expected no pulse", done, ferr, data);
      end else begin
        cur = exp_q.pop_front();
        chk("pulse_kind_ferr", {31'd0, ferr}, {31'd0, cur.err});
        chk("data", {24'd0, data}, {24'd0, cur.d});
        lat = cyc - cur.t0;
        checks++;
        if (lat < 152 || lat > 157) begin
          errors++;
          $display("FAIL latency: got %0d expected 152..157", lat);
        end
      end
    end
    prev_pulse = done || ferr;
  end
  // a frame is start bit, 8 data bits LSB first, first stop bit, optional idle-high second stop bit
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int nbits, input bit push);
    logic [10:0] bits;
    bits = {1'b1, stop_ok, d, 1'b0};
    @(posedge clk); #2;
    if (push) begin
      exp_q.push_back('{err: !stop_ok, d: stop_ok ? d : last_good, t0: cyc});
      if (stop_ok) last_good = d;
    end
    for (int i = 0; i < nbits; i++) begin
      serial = bits[i];
      repeat (16) @(posedge clk);
      #2;
    end
    serial = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_data", {24'd0, data}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_ferr", {31'd0, ferr}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'hA5, 1'b1, 11, 1'b1);
    send_frame(8'h00, 1'b1, 10, 1'b1);
    send_frame(8'hFF, 1'b1, 10, 1'b1);
    repeat (20) @(posedge clk);
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #2;
      serial = (i < 4) ? 1'b0 : 1'b1;
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", {31'd0, seen}, 1);
    chk("glitch_busy_clear", {31'd0, busy}, 0);
    chk("glitch_data_held", {24'd0, data}, {24'd0, last_good});
    send_frame(8'h3C, 1'b1, 10, 1'b1);
    send_frame(8'h81, 1'b0, 10, 1'b1);
    repeat (4) @(posedge clk);
    send_frame(8'h55, 1'b1, 10, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    exp_q.push_back('{err: 1'b1, d: last_good, t0: cyc});
    serial = 1'b0;
    repeat (320) @(posedge clk);
    #2;
    chk("break_busy_mid", {31'd0, busy}, 1);
    repeat (320) @(posedge clk);
    #2;
    chk("break_busy_end", {31'd0, busy}, 1);
    serial = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("break_busy_released", {31'd0, busy}, 0);
    chk("break_data_held", {24'd0, data}, {24'd0, last_good});
    send_frame(8'hC3, 1'b1, 5, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_reset_data", {24'd0, data}, 0);
    chk("async_reset_busy", {31'd0, busy}, 0);
    chk("async_reset_done", {31'd0, done}, 0);
    chk("async_reset_ferr", {31'd0, ferr}, 0);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(8'h5A, 1'b1, 10, 1'b1);
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit ok;
      d = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, ($urandom_range(0, 1) != 0) ? 11 : 10, 1'b1);
      repeat (ok ? $urandom_range(0, 20) : 32 + $urandom_range(0, 20)) @(posedge clk);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
